// File: rtl/dsm_decimator.sv
`timescale 1ns/1ps
// Decimator for a 1-bit delta-sigma stream: counts ones over 2^LOG2_DEC input
// samples and emits one PCM word per window, saturating a full-scale window.
module dsm_decimator #(
  parameter int WIDTH    = 16,
  parameter int LOG2_DEC = 8
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic             s_axis_data_tdata,
  input  logic             s_axis_data_tvalid,
  output logic             s_axis_data_tready,
  output logic [WIDTH-1:0] m_axis_data_tdata,
  output logic             m_axis_data_tuser,
  output logic             m_axis_data_tvalid,
  input  logic             m_axis_data_tready
);

  localparam logic [LOG2_DEC-1:0] PHASE_LAST = '1;

  // Returns {saturated, word}; r can only reach DEC, so its MSB marks full scale.
  function automatic logic [WIDTH:0] map_result(input logic [LOG2_DEC:0] r);
    logic [WIDTH-1:0] w;
    if (r[LOG2_DEC]) begin
      return {1'b1, {WIDTH{1'b1}}};
    end
    w = WIDTH'(r[LOG2_DEC-1:0]) << (WIDTH - LOG2_DEC);
    return {1'b0, w};
  endfunction

  logic [LOG2_DEC-1:0] phase_q, phase_d;
  logic [LOG2_DEC:0]   acc_q, acc_d;
  logic [WIDTH-1:0]    tdata_q, tdata_d;
  logic                tuser_q, tuser_d;
  logic                tvalid_q, tvalid_d;

  logic                in_hs;
  logic                out_hs;
  logic                win_end;
  logic [LOG2_DEC:0]   result;
  logic [WIDTH:0]      mapped;

  // Only the window-closing sample needs to wait for a free output register.
  assign s_axis_data_tready = !((phase_q == PHASE_LAST) && tvalid_q && !m_axis_data_tready);
  assign in_hs   = s_axis_data_tvalid && s_axis_data_tready;
  assign out_hs  = tvalid_q && m_axis_data_tready;
  assign win_end = in_hs && (phase_q == PHASE_LAST);
  assign result  = acc_q + {{LOG2_DEC{1'b0}}, s_axis_data_tdata};
  assign mapped  = map_result(result);

  always_comb begin
    phase_d  = phase_q;
    acc_d    = acc_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tvalid_d = tvalid_q;
    if (in_hs) begin
      phase_d = phase_q + LOG2_DEC'(1);
      acc_d   = win_end ? '0 : result;
    end
    if (win_end) begin
      tdata_d  = mapped[WIDTH-1:0];
      tuser_d  = mapped[WIDTH];
      tvalid_d = 1'b1;
    end else if (out_hs) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      phase_q  <= '0;
      acc_q    <= '0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      acc_q    <= acc_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign m_axis_data_tdata  = tdata_q;
  assign m_axis_data_tuser  = tuser_q;
  assign m_axis_data_tvalid = tvalid_q;

endmodule
